// File: rtl/pc_gen.sv
// Next-PC generator for the fetch stage: owns the fetch PC, resolves BEQ/BNE/J/JAL/JR/JALR
// targets, and applies redirects with optional branch-delay-slot semantics.
module pc_gen #(
  parameter int unsigned PC_W       = 32,
  parameter bit          DELAY_SLOT = 1'b1,
  parameter logic [31:0] RESET_PC   = 32'hbfc00000,
  parameter logic [31:0] EXC_VECTOR = 32'hbfc00380
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_ready,
  output logic            fetch_valid,
  output logic [PC_W-1:0] pc,
  input  logic            resolve_valid,
  input  logic [PC_W-1:0] br_pc,
  input  logic [5:0]      opcode,
  input  logic [5:0]      funct,
  input  logic            cond_eq,
  input  logic [PC_W-1:0] rf_rdata1,
  input  logic [15:0]     offset,
  input  logic [25:0]     instr_index,
  input  logic            exc_valid,
  output logic            taken,
  output logic [PC_W-1:0] link_addr,
  output logic            addr_err,
  output logic [PC_W-1:0] badvaddr
);

  localparam logic [PC_W-1:0] ResetPc    = RESET_PC[PC_W-1:0];
  localparam logic [PC_W-1:0] ExcVec     = EXC_VECTOR[PC_W-1:0];
  localparam logic [PC_W-1:0] RegionMask = ~PC_W'(28'hfff_ffff);
  localparam logic [PC_W-1:0] LinkOff    = DELAY_SLOT ? PC_W'(8) : PC_W'(4);

  localparam logic [5:0] OpSpecial = 6'b000000;
  localparam logic [5:0] OpJ       = 6'b000010;
  localparam logic [5:0] OpJal     = 6'b000011;
  localparam logic [5:0] OpBeq     = 6'b000100;
  localparam logic [5:0] OpBne     = 6'b000101;
  localparam logic [5:0] FnJr      = 6'b001000;
  localparam logic [5:0] FnJalr    = 6'b001001;

  logic            fetch_valid_q, fetch_valid_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            pending_q, pending_d;
  logic [PC_W-1:0] pending_target_q, pending_target_d;
  logic            addr_err_q, addr_err_d;
  logic [PC_W-1:0] badvaddr_q, badvaddr_d;

  logic [PC_W-1:0] seq_pc, br_off, jmp_target, target;
  logic            xfer, misaligned, accept;

  assign seq_pc     = br_pc + PC_W'(4);
  assign br_off     = PC_W'({{14{offset[15]}}, offset, 2'b00});
  assign jmp_target = (seq_pc & RegionMask) | PC_W'({instr_index, 2'b00});

  always_comb begin
    xfer   = 1'b0;
    target = seq_pc + br_off;
    case (opcode)
      OpBeq:     xfer = cond_eq;
      OpBne:     xfer = !cond_eq;
      OpJ, OpJal: begin
        xfer   = 1'b1;
        target = jmp_target;
      end
      OpSpecial: begin
        if (funct == FnJr || funct == FnJalr) begin
          xfer   = 1'b1;
          target = rf_rdata1;
        end
      end
      default: xfer = 1'b0;
    endcase
  end

  assign taken      = resolve_valid && xfer;
  assign misaligned = target[1:0] != 2'b00;
  assign link_addr  = br_pc + LinkOff;
  assign accept     = fetch_valid_q && fetch_ready;

  always_comb begin
    fetch_valid_d    = 1'b1;
    pc_d             = accept ? pc_q + PC_W'(4) : pc_q;
    pending_d        = pending_q;
    pending_target_d = pending_target_q;
    addr_err_d       = 1'b0;
    badvaddr_d       = badvaddr_q;
    if (exc_valid) begin
      pc_d      = ExcVec;
      pending_d = 1'b0;
    end else if (pending_q) begin
      if (accept) begin
        pc_d      = pending_target_q;
        pending_d = 1'b0;
      end
    end else if (taken) begin
      if (misaligned) begin
        addr_err_d = 1'b1;
        badvaddr_d = target;
      end else if (DELAY_SLOT && !accept && pc_q == seq_pc) begin
        // Delay slot still waiting to be fetched: hold the target until it is accepted.
        pending_d        = 1'b1;
        pending_target_d = target;
      end else begin
        pc_d = target;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_valid_q    <= 1'b0;
      pc_q             <= ResetPc;
      pending_q        <= 1'b0;
      pending_target_q <= '0;
      addr_err_q       <= 1'b0;
      badvaddr_q       <= '0;
    end else begin
      fetch_valid_q    <= fetch_valid_d;
      pc_q             <= pc_d;
      pending_q        <= pending_d;
      pending_target_q <= pending_target_d;
      addr_err_q       <= addr_err_d;
      badvaddr_q       <= badvaddr_d;
    end
  end

  assign fetch_valid = fetch_valid_q;
  assign pc          = pc_q;
  assign addr_err    = addr_err_q;
  assign badvaddr    = badvaddr_q;

endmodule
